alu_decoder_seq: RTL and testbench

ALU_DECODER_SEQ -- requirements
Module: alu_decoder_seq

---
 rtl/alu_decoder_seq.sv | 159 +++++++++++++++
 tb/tb_alu_decoder_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_decoder_seq.sv
// ============================================================================
// Module      : alu_decoder_seq
// Description : Four-phase processor-cycle sequencer decoding ALU ROM, B-reg
//               and one-hot action strobes, with a multi-cycle shift/rotate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder_seq #(
    parameter int              AW         = 5,
    parameter logic [1:0]      ALU_SEL    = 2'b10,
    parameter logic [AW-1:0]   BREG       = 5'b11000,
    parameter int              ACTW       = 4,
    parameter int              NACT       = 8,
    parameter int              SRU_CODE   = 7,
    parameter int              SRU_CYCLES = 4
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             cycle_start,
    input  logic [AW-1:0]    raddr,
    input  logic [AW-1:0]    waddr,
    input  logic [ACTW-1:0]  action,
    output logic             nt34,
    output logic             nromoe,
    output logic             nread_alu_b,
    output logic             nwrite_alu_b,
    output logic [NACT-1:0]  naction,
    output logic             nbusy,
    output logic             overrun
);

    localparam int              CW          = $clog2(SRU_CYCLES + 1);
    localparam logic [CW-1:0]   C_SRU_SHIFT = CW'(SRU_CYCLES - 2);
    localparam logic [ACTW-1:0] C_SRU_ACT   = ACTW'(SRU_CODE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t          r_state, w_state;
    logic [1:0]      r_phase, w_phase;
    logic            r_pending, w_pending;
    logic            w_overrun;
    logic [CW-1:0]   r_sru_cnt, w_sru_cnt;
    logic [AW-1:0]   r_raddr, w_raddr;
    logic [AW-1:0]   r_waddr, w_waddr;
    logic [ACTW-1:0] r_action, w_action;

    logic            w_accept_pt, w_accept;
    logic            w_ph2, w_ph23, w_sru_on;
    logic [NACT-1:0] w_naction;

    // Accept points: idle, end of a plain cycle, or the last SRU strobe clock.
    always_comb begin
        w_accept_pt = (r_state == ST_IDLE)
                   || (r_state == ST_RUN && r_phase == 2'd3 && r_sru_cnt == '0)
                   || (r_state == ST_SHIFT && r_sru_cnt == CW'(1));
        w_accept    = w_accept_pt && (cycle_start || r_pending);

        w_state   = r_state;
        w_phase   = r_phase;
        w_pending = r_pending;
        w_overrun = overrun;
        w_sru_cnt = r_sru_cnt;
        w_raddr   = r_raddr;
        w_waddr   = r_waddr;
        w_action  = r_action;

        if (w_accept) begin
            // A request arriving alongside a consumed pending one is kept.
            w_pending = r_pending && cycle_start;
            w_state   = ST_RUN;
            w_phase   = 2'd0;
            w_raddr   = raddr;
            w_waddr   = waddr;
            w_action  = action;
            w_sru_cnt = (action == C_SRU_ACT) ? C_SRU_SHIFT : '0;
        end else begin
            if (cycle_start) begin
                if (r_pending) begin
                    w_overrun = 1'b1;
                end else begin
                    w_pending = 1'b1;
                end
            end
            case (r_state)
                ST_RUN: begin
                    if (r_phase != 2'd3) begin
                        w_phase = r_phase + 2'd1;
                    end else if (r_sru_cnt != '0) begin
                        w_state = ST_SHIFT;
                    end else begin
                        w_state = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    w_sru_cnt = r_sru_cnt - CW'(1);
                    if (r_sru_cnt == CW'(1)) begin
                        w_state = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes decode the next state so the registered outputs line up with it.
    always_comb begin
        w_ph23    = (w_state == ST_RUN) && w_phase[1];
        w_ph2     = (w_state == ST_RUN) && (w_phase == 2'd2);
        w_sru_on  = (w_action == C_SRU_ACT) && (w_ph23 || w_state == ST_SHIFT);
        w_naction = '1;
        for (int i = 1; i < NACT; i++) begin
            if (w_action == ACTW'(i) && (w_sru_on || (w_ph2 && i != SRU_CODE))) begin
                w_naction[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state      <= ST_IDLE;
            r_phase      <= 2'd0;
            r_pending    <= 1'b0;
            r_sru_cnt    <= '0;
            r_raddr      <= '0;
            r_waddr      <= '0;
            r_action     <= '0;
            overrun      <= 1'b0;
            nt34         <= 1'b1;
            nromoe       <= 1'b1;
            nread_alu_b  <= 1'b1;
            nwrite_alu_b <= 1'b1;
            naction      <= '1;
            nbusy        <= 1'b1;
        end else begin
            r_state      <= w_state;
            r_phase      <= w_phase;
            r_pending    <= w_pending;
            r_sru_cnt    <= w_sru_cnt;
            r_raddr      <= w_raddr;
            r_waddr      <= w_waddr;
            r_action     <= w_action;
            overrun      <= w_overrun;
            nt34         <= !w_ph23;
            nromoe       <= !(w_ph23 && w_raddr[AW-1:AW-2] == ALU_SEL);
            nread_alu_b  <= !(w_ph23 && w_raddr == BREG);
            nwrite_alu_b <= !(w_ph23 && w_waddr == BREG);
            naction      <= w_naction;
            nbusy        <= !w_sru_on;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_decoder_seq.sv
// ============================================================================
// Module      : tb_alu_decoder_seq
// Description : Scoreboard bench for alu_decoder_seq with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_decoder_seq;

    localparam int SRU_CYCLES = 4;
    localparam logic [12:0] IDLE_V = '1;

    logic       clk = 1'b0;
    logic       nreset;
    logic       cycle_start;
    logic [4:0] raddr, waddr;
    logic [3:0] action;
    logic       nt34, nromoe, nread_alu_b, nwrite_alu_b, nbusy, overrun;
    logic [7:0] naction;

    alu_decoder_seq #(.SRU_CYCLES(SRU_CYCLES)) dut (
        .clk(clk), .nreset(nreset), .cycle_start(cycle_start),
        .raddr(raddr), .waddr(waddr), .action(action),
        .nt34(nt34), .nromoe(nromoe), .nread_alu_b(nread_alu_b),
        .nwrite_alu_b(nwrite_alu_b), .naction(naction), .nbusy(nbusy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [12:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   mon_en   = 0;
    logic [12:0] obs;
    exp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    // kind 2 = phase 2, 3 = phase 3, 4 = SHIFT clock
    function automatic logic [12:0] exp_vec(int kind, logic [4:0] ra, logic [4:0] wa, logic [3:0] act);
        logic [7:0] na;
        logic nt, nro, nrd, nwr, nb;
        bit sru;
        na = '1; nt = 1; nro = 1; nrd = 1; nwr = 1; nb = 1;
        sru = (act == 4'd7);
        if (kind != 4) begin
            nt  = 0;
            nro = !(ra[4:3] == 2'b10);
            nrd = !(ra == 5'd24);
            nwr = !(wa == 5'd24);
        end
        if (act >= 4'd1 && act <= 4'd7 && (kind == 2 || sru)) na[act[2:0]] = 1'b0;
        if (sru) nb = 0;
        return {nt, nro, nrd, nwr, na, nb};
    endfunction

    task automatic push_vec(int t, logic [12:0] v);
        exp_t x;
        x.t = t; x.v = v;
        sb.push_back(x);
    endtask

    task automatic push_cycle(int t0, logic [4:0] ra, logic [4:0] wa, logic [3:0] act);
        push_vec(t0 + 2, exp_vec(2, ra, wa, act));
        push_vec(t0 + 3, exp_vec(3, ra, wa, act));
        if (act == 4'd7)
            for (int k = 0; k < SRU_CYCLES - 2; k++) push_vec(t0 + 4 + k, exp_vec(4, ra, wa, act));
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, req, cyc);
        end
    endtask

    // Monitor: compare whenever an expected entry is due, flag any other activity.
    always @(negedge clk) begin
        if (mon_en) begin
            obs = {nt34, nromoe, nread_alu_b, nwrite_alu_b, naction, nbusy};
            if (sb.size() > 0 && sb[0].t == cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (obs !== e.v) begin
                    n_fail++;
                    $display("FAIL strobes: got %b, required %b (cycle %0d)", obs, e.v, cyc);
                end
            end else if (obs !== IDLE_V) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got %b, required %b (cycle %0d)", obs, IDLE_V, cyc);
            end
        end
    end

    task automatic single(logic [4:0] ra, logic [4:0] wa, logic [3:0] act);
        @(negedge clk);
        raddr = ra; waddr = wa; action = act; cycle_start = 1'b1;
        push_cycle(cyc + 1, ra, wa, act);
        @(negedge clk);
        cycle_start = 1'b0;
        raddr = ~ra; waddr = ~wa; action = 4'd5;
        repeat ((act == 4'd7) ? SRU_CYCLES + 2 : 4) @(negedge clk);
    endtask

    initial begin
        int c;
        nreset = 1'b0; cycle_start = 1'b0; raddr = '0; waddr = '0; action = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({nt34, nromoe, nread_alu_b, nwrite_alu_b, naction, nbusy}), 32'(IDLE_V));
        check("reset_overrun", 32'(overrun), 32'd0);
        nreset = 1'b1;
        mon_en = 1;
        repeat (2) @(negedge clk);

        // Address scan: ROM enable for 16..23, B read only for 24
        for (int i = 0; i < 32; i++) single(5'(i), 5'd0, 4'd0);

        single(5'd0, 5'd24, 4'd1);
        single(5'd3, 5'd24, 4'd4);
        single(5'd24, 5'd0, 4'd9);
        single(5'd16, 5'd0, 4'd0);
        single(5'd17, 5'd24, 4'd7);

        // Back-to-back plain cycles: second phase 0 right after phase 3
        @(negedge clk); c = cyc;
        raddr = 5'd24; waddr = 5'd0; action = 4'd1; cycle_start = 1'b1;
        push_cycle(c + 1, 5'd24, 5'd0, 4'd1);
        @(negedge clk);
        raddr = 5'd16; waddr = 5'd24; action = 4'd2;
        push_cycle(c + 5, 5'd16, 5'd24, 4'd2);
        @(negedge clk);
        cycle_start = 1'b0;
        repeat (8) @(negedge clk);

        // SRU followed by a pending cycle right after the last strobe clock
        c = cyc;
        raddr = 5'd0; waddr = 5'd0; action = 4'd7; cycle_start = 1'b1;
        push_cycle(c + 1, 5'd0, 5'd0, 4'd7);
        @(negedge clk);
        raddr = 5'd24; waddr = 5'd5; action = 4'd3;
        push_cycle(c + 1 + SRU_CYCLES + 2, 5'd24, 5'd5, 4'd3);
        @(negedge clk);
        cycle_start = 1'b0;
        repeat (10) @(negedge clk);
        check("overrun_clear", 32'(overrun), 32'd0);

        // Three requests during one SRU cycle: one executes, overrun sticks
        c = cyc;
        raddr = 5'd16; waddr = 5'd0; action = 4'd7; cycle_start = 1'b1;
        push_cycle(c + 1, 5'd16, 5'd0, 4'd7);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            cycle_start = (k == 2 || k == 4 || k == 5);
            if (k == 2) begin
                raddr = 5'd24; waddr = 5'd24; action = 4'd2;
                push_cycle(c + 7, 5'd24, 5'd24, 4'd2);
            end
        end
        repeat (8) @(negedge clk);
        check("overrun_set", 32'(overrun), 32'd1);

        // Reset in phase 2 of an SRU cycle with a request pending
        c = cyc;
        raddr = 5'd24; waddr = 5'd24; action = 4'd7; cycle_start = 1'b1;
        push_vec(c + 3, exp_vec(2, 5'd24, 5'd24, 4'd7));
        @(negedge clk);
        @(negedge clk);
        cycle_start = 1'b0;
        @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        check("midcycle_reset_outputs", 32'({nt34, nromoe, nread_alu_b, nwrite_alu_b, naction, nbusy}), 32'(IDLE_V));
        check("midcycle_reset_overrun", 32'(overrun), 32'd0);
        nreset = 1'b1;
        repeat (12) @(negedge clk);

        single(5'd16, 5'd24, 4'd3);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
